// File: rtl/ysyx_23060096_pkg.sv
// Shared types and constants for the NPC writeback slice.
// Holds the result-channel bundle used by EXU and LSU.
package ysyx_23060096_pkg;

  localparam int REG_AW     = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0]     rd;
    logic                  wen;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_23060096_scoreboard.sv
// Per-register busy bits for issue stalls.
// Clear and set are applied on the same edge; x0 never reads busy.
module ysyx_23060096_scoreboard #(
  parameter int NREG   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_idx_i,
  input  logic [REG_AW-1:0] qa_idx_i,
  input  logic [REG_AW-1:0] qb_idx_i,
  output logic              qa_busy_o,
  output logic              qb_busy_o,
  output logic [NREG-1:0]   busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign qa_busy_o = busy_q[qa_idx_i];
  assign qb_busy_o = busy_q[qb_idx_i];
  assign busy_o    = busy_q;

endmodule

// File: rtl/ysyx_23060096_wb_unit.sv
// Writeback unit: arbitrates EXU/LSU results onto the regfile write port,
// tracks pending destinations and forwards the in-flight write.
module ysyx_23060096_wb_unit #(
  parameter int REG_AW     = ysyx_23060096_pkg::REG_AW,
  parameter int DATA_WIDTH = ysyx_23060096_pkg::DATA_WIDTH,
  parameter int NREG       = 2 ** REG_AW
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  iss_valid,
  input  logic [REG_AW-1:0]     iss_rd,
  input  logic                  iss_wen,
  output logic                  iss_ready,
  input  logic                  exu_valid,
  input  logic [REG_AW-1:0]     exu_rd,
  input  logic                  exu_wen,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_AW-1:0]     lsu_rd,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic [REG_AW-1:0]     rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_wen,
  input  logic [REG_AW-1:0]     qa,
  input  logic [REG_AW-1:0]     qb,
  output logic                  qa_busy,
  output logic                  qb_busy,
  output logic                  qa_fwd,
  output logic                  qb_fwd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  err
);

  import ysyx_23060096_pkg::*;

  wb_req_t req;
  logic    acc;
  logic    req_write;
  logic    iss_set;

  logic [NREG-1:0]       busy;
  logic                  sb_qa_busy;
  logic                  sb_qb_busy;

  logic                  rf_wen_q;
  logic [REG_AW-1:0]     rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic                  err_q;

  assign lsu_ready = 1'b1;
  assign exu_ready = !lsu_valid;

  // LSU always wins; both valid is legal, hence priority not unique
  always_comb begin
    req = '0;
    acc = 1'b0;
    priority case (1'b1)
      lsu_valid: begin
        req = '{rd: lsu_rd, wen: lsu_wen, data: lsu_data};
        acc = 1'b1;
      end
      exu_valid: begin
        req = '{rd: exu_rd, wen: exu_wen, data: exu_data};
        acc = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_write = acc && req.wen && (req.rd != REG_ZERO);

  assign iss_ready = !(iss_wen && (iss_rd != REG_ZERO) && busy[iss_rd]);
  assign iss_set   = iss_valid && iss_ready && iss_wen
                     && (iss_rd != REG_ZERO);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_wen_q <= req_write;
      if (acc) begin
        rf_waddr_q <= req.rd;
        rf_wdata_q <= req.data;
      end
      if (req_write && !busy[req.rd]) err_q <= 1'b1;
    end
  end

  ysyx_23060096_scoreboard #(
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .set_en_i  (iss_set),
    .set_idx_i (iss_rd),
    .clr_en_i  (rf_wen_q),
    .clr_idx_i (rf_waddr_q),
    .qa_idx_i  (qa),
    .qb_idx_i  (qb),
    .qa_busy_o (sb_qa_busy),
    .qb_busy_o (sb_qb_busy),
    .busy_o    (busy)
  );

  assign qa_fwd  = rf_wen_q && (rf_waddr_q == qa) && (qa != REG_ZERO);
  assign qb_fwd  = rf_wen_q && (rf_waddr_q == qb) && (qb != REG_ZERO);
  assign qa_busy = sb_qa_busy && !qa_fwd;
  assign qb_busy = sb_qb_busy && !qb_fwd;

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign fwd_data = rf_wdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ysyx_23060096_wb_unit.sv
// Scoreboard bench for the writeback unit: directed scenarios, then
// randomized traffic against a set/queue reference model.
module tb_ysyx_23060096_wb_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        iss_valid, iss_wen, iss_ready;
  logic [4:0]  iss_rd;
  logic        exu_valid, exu_wen, exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_wen, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic [4:0]  qa, qb;
  logic        qa_busy, qb_busy, qa_fwd, qb_fwd;
  logic [31:0] fwd_data;
  logic        err;

  always #5 clk = ~clk;

  ysyx_23060096_wb_unit dut (
    .clk(clk), .rstn(rstn),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_wen(iss_wen),
    .iss_ready(iss_ready),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_wen(exu_wen),
    .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wen(lsu_wen),
    .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .qa(qa), .qb(qb), .qa_busy(qa_busy), .qb_busy(qb_busy),
    .qa_fwd(qa_fwd), .qb_fwd(qb_fwd), .fwd_data(fwd_data), .err(err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          stamp;
  } wr_t;

  wr_t        exp_q[$];
  logic [4:0] outst[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  bit          busy_m[32];
  bit          err_m;
  bit          infl_v;
  logic [4:0]  infl_rd;
  logic [31:0] infl_data;
  bit          exu_pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic bit pend(logic [4:0] r);
    return (r != 0) && busy_m[r];
  endfunction

  task automatic check_comb();
    bit fa, fb;
    fa = infl_v && (infl_rd == qa) && (qa != 0);
    fb = infl_v && (infl_rd == qb) && (qb != 0);
    chk("iss_ready", iss_ready, !(iss_wen && pend(iss_rd)));
    chk("exu_ready", exu_ready, !lsu_valid);
    chk("lsu_ready", lsu_ready, 1);
    chk("qa_fwd", qa_fwd, fa);
    chk("qb_fwd", qb_fwd, fb);
    chk("qa_busy", qa_busy, pend(qa) && !fa);
    chk("qb_busy", qb_busy, pend(qb) && !fb);
    chk("err", err, err_m);
    chk("rf_wen", rf_wen, infl_v);
    if (infl_v) chk("fwd_data", fwd_data, infl_data);
  endtask

  // Reference update for one rising edge, from the inputs now applied
  task automatic model_edge();
    logic [4:0]  rd;
    logic        wen, wr, rdy;
    logic [31:0] d;
    rd = lsu_valid ? lsu_rd : exu_rd;
    wen = lsu_valid ? lsu_wen : exu_wen;
    d = lsu_valid ? lsu_data : exu_data;
    wr = (lsu_valid || exu_valid) && wen && (rd != 0);
    rdy = !(iss_wen && pend(iss_rd));
    exu_pend = exu_valid && lsu_valid;
    if (wr && !pend(rd)) err_m = 1;
    if (wr) exp_q.push_back('{rd: rd, data: d, stamp: cyc + 1});
    if (infl_v) busy_m[infl_rd] = 0;
    if (iss_valid && rdy && iss_wen && iss_rd != 0) begin
      busy_m[iss_rd] = 1;
      outst.push_back(iss_rd);
    end
    infl_v = wr;
    infl_rd = rd;
    infl_data = d;
  endtask

  task automatic cycle();
    #1 check_comb();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    iss_valid = 0; iss_rd = 0; iss_wen = 0;
    exu_valid = 0; exu_rd = 0; exu_wen = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wen = 0; lsu_data = 0;
    qa = 0; qb = 0;
  endtask

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 0;
    err_m = 0;
    infl_v = 0;
    infl_rd = 0;
    infl_data = 0;
    exu_pend = 0;
    exp_q.delete();
    outst.delete();
  endtask

  task automatic gen(output logic [4:0] rd, output logic wen,
                     output logic [31:0] d);
    if (outst.size() > 0 && $urandom % 8 != 0) begin
      int i;
      i = $urandom_range(0, outst.size() - 1);
      rd = outst[i];
      outst.delete(i);
      wen = 1;
    end else begin
      rd = 5'($urandom);
      wen = 1'($urandom);
    end
    d = $urandom;
  endtask

  // Scoreboard monitor: every committed write must match the oldest
  // accepted result and appear exactly one cycle after acceptance
  always @(negedge clk) begin
    if (rstn === 1'b1 && rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd %0d data %0h expected none",
                 rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_addr", rf_waddr, e.rd);
        chk("wb_data", rf_wdata, e.data);
        chk("wb_fwd_data", fwd_data, e.data);
        chk("wb_cycle", cyc, e.stamp);
      end
    end
  end

  initial begin
    idle_in();
    model_reset();
    rstn = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1;

    // Quiet after reset
    iss_rd = 5; iss_wen = 1;
    #1;
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_err", err, 0);
    chk("rst_iss_ready", iss_ready, 1);
    for (int i = 0; i < 32; i++) begin
      qa = 5'(i);
      #1 chk("rst_qa_busy", qa_busy, 0);
    end
    @(negedge clk);
    idle_in();

    // Issue rd5, result two cycles later, forward, then clear
    iss_valid = 1; iss_rd = 5; iss_wen = 1; cycle();
    idle_in(); qa = 5; cycle();
    chk("busy5_set", qa_busy, 1);
    exu_valid = 1; exu_rd = 5; exu_wen = 1; exu_data = 32'hDEADBEEF;
    qa = 5; cycle();
    idle_in(); qa = 5; #1;
    chk("fwd5", qa_fwd, 1);
    chk("fwd5_data", fwd_data, 32'hDEADBEEF);
    chk("fwd5_busy", qa_busy, 0);
    cycle();
    qa = 5; #1 chk("busy5_clr", qa_busy, 0);
    cycle();

    // Simultaneous LSU and EXU results
    iss_valid = 1; iss_rd = 3; iss_wen = 1; cycle();
    iss_rd = 4; cycle();
    idle_in();
    lsu_valid = 1; lsu_rd = 3; lsu_wen = 1; lsu_data = 32'h11;
    exu_valid = 1; exu_rd = 4; exu_wen = 1; exu_data = 32'h22;
    #1 chk("arb_exu_ready", exu_ready, 0);
    cycle();
    lsu_valid = 0; cycle();
    idle_in(); cycle(); cycle();

    // WAW stall on rd7
    iss_valid = 1; iss_rd = 7; iss_wen = 1; cycle();
    #1 chk("waw_stall", iss_ready, 0);
    exu_valid = 1; exu_rd = 7; exu_wen = 1; exu_data = 32'h77;
    cycle();
    exu_valid = 0;
    #1 chk("waw_inflight", iss_ready, 0);
    cycle();
    #1 chk("waw_release", iss_ready, 1);
    cycle();
    idle_in();

    // Write to x0 consumed silently
    exu_valid = 1; exu_rd = 0; exu_wen = 1; exu_data = 32'h55; cycle();
    idle_in(); #1;
    chk("x0_rf_wen", rf_wen, 0);
    chk("x0_err", err, 0);
    cycle();

    // Unexpected write raises sticky err, then async reset mid-stream
    iss_valid = 1; iss_rd = 12; iss_wen = 1; cycle();
    idle_in();
    lsu_valid = 1; lsu_rd = 9; lsu_wen = 1; lsu_data = 32'h99; cycle();
    idle_in(); #1;
    chk("err9", err, 1);
    chk("wr9", rf_wen, 1);
    cycle();
    #1 chk("err_sticky", err, 1);
    rstn = 0;
    model_reset();
    qa = 12; #1;
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rf_wen", rf_wen, 0);
    chk("mid_rst_busy", qa_busy, 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1;
    idle_in();
    cycle();

    // Randomized traffic
    outst.delete();
    for (int n = 0; n < 1500; n++) begin
      if (!exu_pend) begin
        exu_valid = ($urandom % 3 == 0);
        if (exu_valid) gen(exu_rd, exu_wen, exu_data);
      end
      lsu_valid = ($urandom % 4 == 0);
      if (lsu_valid) gen(lsu_rd, lsu_wen, lsu_data);
      iss_valid = 1'($urandom);
      iss_rd = 5'($urandom);
      iss_wen = ($urandom % 4 != 0);
      qa = 5'($urandom);
      qb = 5'($urandom);
      cycle();
    end
    idle_in();
    cycle(); cycle(); cycle();
    chk("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060096_wb_unit.md
Name: ysyx_23060096_wb_unit

Overview:
- Writeback unit: the write-side initiator for the NPC general-purpose register file.
- Accepts results from EXU and LSU over valid/ready channels and arbitrates between them.
- Drives the register file's single write port (waddr/wdata/w_en) one cycle later.
- Keeps a per-register busy scoreboard for issue stalls, and exposes a forwarding path for the in-flight write.

Parameters:
- REG_AW, 5, register index width.
- DATA_WIDTH, 32, register data width.
- NREG, 32, register count (2**REG_AW); x0 is hardwired zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- iss_valid  in  1  decode wants to issue an instruction.
- iss_rd  in  REG_AW  destination register of the issuing instruction.
- iss_wen  in  1  issuing instruction writes rd.
- iss_ready  out  1  issue may proceed (combinational).
- exu_valid  in  1  EXU result valid.
- exu_rd  in  REG_AW  EXU destination.
- exu_wen  in  1  EXU result writes rd.
- exu_data  in  DATA_WIDTH  EXU result.
- exu_ready  out  1  EXU result accepted (combinational).
- lsu_valid, lsu_rd, lsu_wen, lsu_data, lsu_ready: same as the EXU channel, for loads.
- rf_waddr  out  REG_AW  register file write address (registered).
- rf_wdata  out  DATA_WIDTH  register file write data (registered).
- rf_wen  out  1  register file write enable (registered).
- qa, qb  in  REG_AW  source registers being queried by decode.
- qa_busy, qb_busy  out  1  source has a pending write not yet forwardable.
- qa_fwd, qb_fwd  out  1  source matches the write on rf_* this cycle.
- fwd_data  out  DATA_WIDTH  equals rf_wdata.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (asynchronous, rstn=0): scoreboard all 0, rf_wen=0, rf_waddr=0, rf_wdata=0, err=0. Reset mid-transfer drops any accepted result.
- Arbitration: fixed priority, LSU over EXU.
  - lsu_ready=1 always.
  - exu_ready = !lsu_valid.
  - At most one result accepted per cycle.
- Accept to write latency is 1 cycle. On the edge that accepts a result:
  - rf_wen <= wen && rd!=0.
  - rf_waddr <= rd.
  - rf_wdata <= data.
  - With no acceptance, rf_wen <= 0. rf_waddr and rf_wdata hold.
- Scoreboard clear: busy[rf_waddr] clears on the same edge the register file commits (rf_wen=1).
- Scoreboard set: iss_valid && iss_ready && iss_wen && iss_rd!=0 sets busy[iss_rd] on that edge.
- iss_ready = !(iss_wen && iss_rd!=0 && busy[iss_rd]). This blocks WAW.
  - A register whose clear is in flight this cycle still blocks issue.
  - Set and clear of the same index therefore never coincide.
- qa_fwd = rf_wen && rf_waddr==qa && qa!=0. qb_fwd is the same for qb.
- qa_busy = busy[qa] && !qa_fwd. qb_busy is the same for qb. Index 0 always reads not busy.
- Results with wen=0 or rd=0 are accepted and consumed. They cause no write and no scoreboard change.
- Error: a result accepted with wen=1, rd!=0 and busy[rd]=0 sets err=1. err holds until reset, and the write still proceeds.
- Back-to-back results to the same rd are committed in acceptance order.

Decomposition:
- Shared package ysyx_23060096_pkg holds:
  - REG_AW and DATA_WIDTH defaults.
  - REG_ZERO index constant.
  - A wb_req struct {rd, wen, data} used by the EXU and LSU channels.
- One sub-module, ysyx_23060096_scoreboard:
  - NREG busy bits with set and clear ports.
  - Two combinational query ports.
  - Async active-low reset.

Test Plan:
- Reset release, no traffic -> rf_wen=0, iss_ready=1 for rd=5, qa_busy=0 for all qa, err=0.
- Issue rd=5, then EXU result rd=5 data=0xDEADBEEF two cycles later:
  - busy[5]=1 from the cycle after issue.
  - rf_wen=1, waddr=5, wdata=0xDEADBEEF one cycle after acceptance; qa=5 gives qa_fwd=1, qa_busy=0 that cycle.
  - busy[5]=0 afterwards.
- Same cycle lsu(rd=3, 0x11) and exu(rd=4, 0x22), both issued -> lsu_ready=1, exu_ready=0. Writes are rd3=0x11 then rd4=0x22 on consecutive cycles.
- Issue rd=7 while busy[7]=1 -> iss_ready=0. After the rd=7 writeback commits, iss_ready=1.
- EXU result rd=0 wen=1 data=0x55 -> accepted, rf_wen stays 0, err=0.
- LSU result rd=9 wen=1 with busy[9]=0 -> write of rd9 occurs and err=1 sticky. Asserting rstn=0 mid-stream clears err, busy and rf_wen immediately.
